// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register file write port, with a per-register pending scoreboard.
// Optional macro WB_ARB_BYPASS_EN: hazard queries report not-busy in the cycle the pending write lands.
module regfile_wb_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*5-1:0]    req_addr,
   input  logic [NUM_REQ*XLEN-1:0] req_data,
   input  logic                    iss_valid,
   input  logic [4:0]              iss_rd,
   input  logic [4:0]              q_addr_0,
   input  logic [4:0]              q_addr_1,
   output logic                    q_busy_0,
   output logic                    q_busy_1,
   output logic [31:0]             busy_mask,
   output logic                    rf_w_en,
   output logic [4:0]              rf_w_addr,
   output logic [XLEN-1:0]         rf_w_data,
   output logic                    wb_unexp
);

   logic [1:0]         rr_ptr_q;
   logic [1:0]         rr_ptr_d;
   logic [NUM_REQ-1:0] grant_s;
   logic [1:0]         grant_idx_s;
   logic               grant_any_s;
   int                 scan_idx_s;
   logic [4:0]         sel_addr_s;
   logic [XLEN-1:0]    sel_data_s;

   logic               wr_en_q;
   logic [4:0]         wr_addr_q;
   logic [XLEN-1:0]    wr_data_q;
   logic [31:0]        busy_q;
   logic [31:0]        busy_d;
   logic [31:0]        set_s;
   logic [31:0]        clr_s;
   logic               unexp_q;

   // Round-robin scan starting one past the last granted requester
   always_comb begin
      grant_s     = '0;
      grant_idx_s = rr_ptr_q;
      grant_any_s = 1'b0;
      scan_idx_s  = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx_s = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!grant_any_s && req_valid[scan_idx_s]) begin
            grant_any_s          = 1'b1;
            grant_s[scan_idx_s]  = 1'b1;
            grant_idx_s          = 2'(scan_idx_s);
         end else begin
            grant_any_s = grant_any_s;
         end
      end
      rr_ptr_d = grant_any_s ? grant_idx_s : rr_ptr_q;
   end

   assign req_ready  = grant_s;
   assign sel_addr_s = req_addr[5*int'(grant_idx_s) +: 5];
   assign sel_data_s = req_data[XLEN*int'(grant_idx_s) +: XLEN];

   // Issue sets a pending bit, a landed write clears it; set wins and x0 never tracks
   always_comb begin
      set_s  = iss_valid ? (32'd1 << iss_rd) : 32'd0;
      clr_s  = wr_en_q ? (32'd1 << wr_addr_q) : 32'd0;
      busy_d = (set_s | (busy_q & ~clr_s)) & ~32'd1;
   end

   // Write stage, scoreboard and arbitration pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q  <= 2'(NUM_REQ - 1);
         wr_en_q   <= 1'b0;
         wr_addr_q <= 5'd0;
         wr_data_q <= '0;
         busy_q    <= 32'd0;
         unexp_q   <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         busy_q   <= busy_d;
         unexp_q  <= wr_en_q && !busy_q[wr_addr_q];
         if (grant_any_s) begin
            // x0 writes are consumed but never reach the register file
            wr_en_q   <= (sel_addr_s != 5'd0);
            wr_addr_q <= sel_addr_s;
            wr_data_q <= sel_data_s;
         end else begin
            wr_en_q <= 1'b0;
         end
      end
   end

   assign rf_w_en   = wr_en_q;
   assign rf_w_addr = wr_addr_q;
   assign rf_w_data = wr_data_q;
   assign busy_mask = busy_q;
   assign wb_unexp  = unexp_q;

`ifdef WB_ARB_BYPASS_EN
   assign q_busy_0 = busy_q[q_addr_0] & ~(wr_en_q && (wr_addr_q == q_addr_0));
   assign q_busy_1 = busy_q[q_addr_1] & ~(wr_en_q && (wr_addr_q == q_addr_1));
`else
   assign q_busy_0 = busy_q[q_addr_0];
   assign q_busy_1 = busy_q[q_addr_1];
`endif

endmodule
